muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide unit in the EX stage of the mp4 pipeline.
- Accepts one operation on `start`, computes it over multiple cycles, then presents a registered `result`.
- `result` is one data input of the writeback-select mux; that mux's select is the MULDIV code while `done` is high.
- Pipeline stalls EX while `busy` is high. Pipeline flushes cancel the operation through `kill`.

---
 rtl/muldiv_unit.sv | 94 +++++++++
 tb/tb_muldiv_unit.sv | 166 ++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// muldiv_unit: iterative RV32M multiply/divide unit (shift-add multiply, restoring divide)
module muldiv_unit #(
    parameter int width = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       funct3,
    input  logic [width-1:0] a,
    input  logic [width-1:0] b,
    input  logic             kill,
    output logic             busy,
    output logic             done,
    output logic [width-1:0] result
);
    localparam int cw = $clog2(width);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t             state, state_next;
    logic [cw-1:0]      cnt;
    logic [2*width-1:0] acc, acc_next, prod;
    logic [width-1:0]   dvs, mag_a, mag_b, spec_val, quo, rem, res_next;
    logic [width:0]     mul_sum, div_sh, div_diff;
    logic [2:0]         op;
    logic               neg, spec, accept, special, sign_a, sign_b, div_op;

    // Operand conditioning at accept, one datapath step, and final sign/half selection
    always_comb begin
        accept   = state == IDLE && start && !kill;
        div_op   = funct3[2];
        sign_a   = a[width-1] && !(funct3[0] && funct3 != 3'd1);
        sign_b   = b[width-1] && (funct3[2] ? !funct3[0] : !funct3[1]);
        mag_a    = sign_a ? -a : a;
        mag_b    = sign_b ? -b : b;
        special  = div_op && (b == '0 || (!funct3[0] && a == {1'b1, {(width-1){1'b0}}} && b == '1));
        spec_val = b == '0 ? (funct3[1] ? a : '1) : (funct3[1] ? '0 : a);
        mul_sum  = {1'b0, acc[2*width-1:width]} + (acc[0] ? {1'b0, dvs} : '0);
        div_sh   = {acc[2*width-1:width], acc[width-1]};
        div_diff = div_sh - {1'b0, dvs};
        acc_next = op[2] ? (div_diff[width] ? {div_sh[width-1:0], acc[width-2:0], 1'b0}
                                            : {div_diff[width-1:0], acc[width-2:0], 1'b1})
                         : {mul_sum, acc[width-1:1]};
        prod     = neg ? -acc_next : acc_next;
        quo      = acc_next[width-1:0];
        rem      = acc_next[2*width-1:width];
        res_next = spec ? acc[width-1:0]
                 : !op[2] ? (op == 3'd0 ? prod[width-1:0] : prod[2*width-1:width])
                 : op[1] ? (neg ? -rem : rem) : (neg ? -quo : quo);
    end

    // Next-state logic; kill always returns to IDLE
    always_comb begin
        state_next = state;
        state_next = kill ? IDLE
                   : state == IDLE ? (start ? CALC : IDLE)
                   : state == CALC ? (cnt == '0 ? DONE : CALC)
                   : IDLE;
    end

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= state_next;
    end

    // Datapath: latch magnitudes on accept, iterate in CALC, write result on entry to DONE
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            op     <= '0;
            spec   <= 1'b0;
            neg    <= 1'b0;
            cnt    <= '0;
            dvs    <= '0;
            acc    <= '0;
            result <= '0;
        end else if (accept) begin
            op   <= funct3;
            spec <= special;
            neg  <= (div_op && funct3[1]) ? sign_a : sign_a ^ sign_b;
            cnt  <= special ? '0 : cw'(width - 1);
            dvs  <= div_op ? mag_b : mag_a;
            acc  <= special ? {{width{1'b0}}, spec_val}
                  : {{width{1'b0}}, div_op ? mag_a : mag_b};
        end else if (state == CALC && !kill) begin
            acc <= acc_next;
            cnt <= cnt - 1'b1;
            if (cnt == '0) result <= res_next;
        end
    end

    assign busy = state != IDLE;
    assign done = state == DONE && !kill;
endmodule

// File: tb/tb_muldiv_unit.sv
// tb_muldiv_unit: directed and randomized checks of muldiv_unit against a 64-bit arithmetic model
module tb_muldiv_unit;
    logic        clk = 0, rst = 0, start = 0, kill = 0;
    logic [2:0]  funct3 = '0;
    logic [31:0] a = '0, b = '0;
    logic        busy, done;
    logic [31:0] result;
    int          tests = 0, fails = 0;
    localparam logic [31:0] MIN = 32'h8000_0000;

    muldiv_unit #(.width(32)) dut (
        .clk(clk), .rst(rst), .start(start), .funct3(funct3), .a(a), .b(b),
        .kill(kill), .busy(busy), .done(done), .result(result)
    );

    always #5 clk = ~clk;

    function automatic logic is_special(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        return f >= 3'd4 && (y == 0 || ((f == 3'd4 || f == 3'd6) && x == MIN && y == 32'hFFFF_FFFF));
    endfunction

    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y);
        longint sx, sy, ux, uy, p;
        logic [63:0] pu;
        sx = $signed(x);
        sy = $signed(y);
        ux = {32'b0, x};
        uy = {32'b0, y};
        case (f)
            3'd0: begin p = sx * sy; return p[31:0]; end
            3'd1: begin p = sx * sy; return p[63:32]; end
            3'd2: begin p = sx * uy; return p[63:32]; end
            3'd3: begin pu = ux * uy; return pu[63:32]; end
            3'd4: begin
                if (y == 0) return 32'hFFFF_FFFF;
                if (x == MIN && y == 32'hFFFF_FFFF) return MIN;
                p = sx / sy;
                return p[31:0];
            end
            3'd5: return (y == 0) ? 32'hFFFF_FFFF : x / y;
            3'd6: begin
                if (y == 0) return x;
                if (x == MIN && y == 32'hFFFF_FFFF) return 32'h0;
                p = sx % sy;
                return p[31:0];
            end
            default: return (y == 0) ? x : x % y;
        endcase
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Issue one op, check busy/done every cycle, result on the done cycle and after it
    task automatic run_op(input logic [2:0] f, input logic [31:0] x, input logic [31:0] y, input bit hold);
        logic [31:0] exp;
        int lat;
        exp = ref_model(f, x, y);
        lat = is_special(f, x, y) ? 1 : 32;
        @(negedge clk);
        start = 1; funct3 = f; a = x; b = y;
        @(posedge clk); #1;
        if (!hold) start = 0;
        a = $urandom; b = $urandom; funct3 = 3'($urandom);
        check("calc_first", {30'b0, busy, done}, 32'b10);
        for (int j = 1; j < lat; j++) begin
            @(posedge clk); #1;
            check("calc", {30'b0, busy, done}, 32'b10);
        end
        @(posedge clk); #1;
        start = 0;
        check("done_pulse", {30'b0, busy, done}, 32'b11);
        check($sformatf("result f=%0d a=%h b=%h", f, x, y), result, exp);
        @(posedge clk); #1;
        check("idle_after", {30'b0, busy, done}, 32'b00);
        check("result_held", result, exp);
    endtask

    initial begin
        logic [31:0] prev, x, y;
        logic [2:0]  f;
        bit          saw_done;
        #12;
        check("reset_busy_done", {30'b0, busy, done}, 32'b0);
        check("reset_result", result, 32'h0);
        @(negedge clk) rst = 1;

        run_op(3'd0, 32'd7, 32'hFFFF_FFFD, 0);
        run_op(3'd1, MIN, MIN, 0);
        run_op(3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        run_op(3'd2, 32'hFFFF_FFFF, 32'd2, 0);
        run_op(3'd4, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd6, 32'hFFFF_FFF9, 32'd2, 0);
        run_op(3'd5, 32'd100, 32'd7, 0);
        run_op(3'd7, 32'd100, 32'd7, 0);
        run_op(3'd5, 32'h1234, 32'd0, 0);
        run_op(3'd7, 32'h1234, 32'd0, 0);
        run_op(3'd4, MIN, 32'hFFFF_FFFF, 0);
        run_op(3'd6, MIN, 32'hFFFF_FFFF, 0);
        run_op(3'd4, 32'h5, 32'd0, 0);
        run_op(3'd6, 32'hFFFF_FF00, 32'd0, 0);

        prev = result;
        @(negedge clk);
        start = 1; funct3 = 3'd0; a = 32'h1234_5678; b = 32'h9ABC_DEF0;
        @(posedge clk); #1;
        start = 0;
        repeat (9) @(posedge clk);
        #1 kill = 1;
        @(posedge clk); #1;
        kill = 0;
        check("kill_busy_done", {30'b0, busy, done}, 32'b0);
        check("kill_result", result, prev);
        saw_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1;
        end
        check("kill_no_done", {31'b0, saw_done}, 32'b0);
        run_op(3'd0, 32'd3, 32'd5, 0);

        @(negedge clk);
        start = 1; funct3 = 3'd5; a = 32'hDEAD_BEEF; b = 32'd3;
        @(posedge clk); #1;
        start = 0;
        repeat (5) @(posedge clk);
        #2 rst = 0;
        #1;
        check("async_reset_busy_done", {30'b0, busy, done}, 32'b0);
        check("async_reset_result", result, 32'h0);
        @(posedge clk); #1;
        @(negedge clk) rst = 1;
        saw_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) saw_done = 1;
        end
        check("reset_no_done", {31'b0, saw_done}, 32'b0);

        run_op(3'd1, 32'h7FFF_FFFF, 32'h8000_0001, 1);
        saw_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) saw_done = 1;
        end
        check("held_start_single_done", {31'b0, saw_done}, 32'b0);

        for (int i = 0; i < 40; i++) begin
            f = 3'($urandom);
            x = $urandom;
            y = $urandom;
            if ($urandom_range(7) == 0) y = 0;
            if ($urandom_range(15) == 0) begin x = MIN; y = 32'hFFFF_FFFF; end
            if ($urandom_range(3) == 0) y = y >> $urandom_range(31);
            run_op(f, x, y, 0);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
